// File: rtl/song_player_pkg.sv
// Shared audio definitions for the song player: player states, datapath widths
// and the square-wave level helper.
package song_player_pkg;

    localparam int ADDR_W   = 10;
    localparam int ROM_W    = 20;
    localparam int TONE_W   = 19;
    localparam int BEAT_W   = 27;
    localparam int SAMPLE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } state_e;

    function automatic logic signed [SAMPLE_W-1:0] square_level(
        input logic                       phase,
        input logic signed [SAMPLE_W-1:0] ampl
    );
        return phase ? -ampl : ampl;
    endfunction

endpackage

// File: rtl/song_player_tone.sv
// Square-wave tone generator: toggles phase every half_period+1 cycles and
// registers a +/-AMPL sample; clear silences it, load restarts it at +AMPL.
module square_tone_gen
    import song_player_pkg::*;
#(
    parameter int signed AMPL = 1000000000
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                clear,
    input  logic                load,
    input  logic [TONE_W-1:0]   half_period,
    input  logic                tone_on,
    output logic [SAMPLE_W-1:0] sample
);

    localparam logic signed [SAMPLE_W-1:0] AMPL_V = SAMPLE_W'(AMPL);

    logic [TONE_W-1:0]   half_period_q, half_period_d;
    logic                tone_on_q, tone_on_d;
    logic [TONE_W-1:0]   cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            half_period_q <= '0;
            tone_on_q     <= 1'b0;
            cnt_q         <= '0;
            phase_q       <= 1'b0;
            sample_q      <= '0;
        end else begin
            half_period_q <= half_period_d;
            tone_on_q     <= tone_on_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            sample_q      <= sample_d;
        end
    end

    always_comb begin
        half_period_d = half_period_q;
        tone_on_d     = tone_on_q;
        cnt_d         = cnt_q;
        phase_d       = phase_q;
        sample_d      = tone_on_q ? square_level(phase_q, AMPL_V) : '0;

        // A rest keeps the counter parked at zero.
        if (tone_on_q) begin
            if (cnt_q == half_period_q) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + TONE_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        if (load) begin
            half_period_d = half_period;
            tone_on_d     = tone_on;
            cnt_d         = '0;
            phase_d       = 1'b0;
        end

        if (clear) begin
            half_period_d = '0;
            tone_on_d     = 1'b0;
            cnt_d         = '0;
            phase_d       = 1'b0;
            sample_d      = '0;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/song_player.sv
// Song player: walks a note ROM with a fixed beat per note (tempo switch part-way),
// optionally looping, and drives a square-wave tone generator for each note.
module song_player
    import song_player_pkg::*;
#(
    parameter int        LAST_ADDR      = 252,
    parameter int        TEMPO_INIT     = 9200000,
    parameter int        TEMPO_FAST     = 7500000,
    parameter int        TEMPO_CHG_ADDR = 197,
    parameter int signed AMPL           = 1000000000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [ROM_W-1:0]    rom_q,
    output logic [SAMPLE_W-1:0] sample,
    output logic                busy,
    output logic                song_end,
    output logic [ADDR_W-1:0]   note_idx
);

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] CHG_A    = ADDR_W'(TEMPO_CHG_ADDR);
    localparam logic [BEAT_W-1:0] LIM_INIT = BEAT_W'(TEMPO_INIT);
    localparam logic [BEAT_W-1:0] LIM_FAST = BEAT_W'(TEMPO_FAST);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0]   note_idx_q, note_idx_d;
    logic [BEAT_W-1:0]   limit_q, limit_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                fetch_cnt_q, fetch_cnt_d;
    logic                tone_load;
    logic                tone_clear;
    logic                rom_q_unused;

    assign rom_q_unused = rom_q[ROM_W-1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            note_idx_q  <= '0;
            limit_q     <= LIM_INIT;
            beat_q      <= '0;
            fetch_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            note_idx_q  <= note_idx_d;
            limit_q     <= limit_d;
            beat_q      <= beat_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        note_idx_d  = note_idx_q;
        limit_d     = limit_q;
        beat_d      = beat_q;
        fetch_cnt_d = fetch_cnt_q;
        tone_load   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    rom_addr_d  = '0;
                    limit_d     = LIM_INIT;
                    fetch_cnt_d = 1'b0;
                end
            end
            ST_FETCH: begin
                // Two cycles to cover the ROM read latency.
                fetch_cnt_d = 1'b1;
                if (fetch_cnt_q) begin
                    fetch_cnt_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tone_load  = 1'b1;
                note_idx_d = rom_addr_q;
                beat_d     = '0;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (beat_q == limit_q) begin
                    if (rom_addr_q != LAST_A) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        if (rom_addr_q == CHG_A) begin
                            limit_d = LIM_FAST;
                        end
                        state_d = ST_FETCH;
                    end else if (loop_en) begin
                        rom_addr_d = '0;
                        limit_d    = LIM_INIT;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop) begin
            state_d     = ST_IDLE;
            fetch_cnt_d = 1'b0;
            tone_load   = 1'b0;
        end
    end

    // Silence follows the next state so the sample is zero in the same cycle
    // the player lands in IDLE or DONE; a restart therefore begins silent.
    assign tone_clear = (state_d == ST_IDLE) || (state_d == ST_DONE);

    square_tone_gen #(
        .AMPL(AMPL)
    ) u_tone (
        .clk        (CLOCK_50),
        .srst       (reset),
        .clear      (tone_clear),
        .load       (tone_load),
        .half_period(rom_q[TONE_W-1:0]),
        .tone_on    (|rom_q[TONE_W-1:0]),
        .sample     (sample)
    );

    assign rom_addr = rom_addr_q;
    assign note_idx = note_idx_q;
    assign busy     = (state_q != ST_IDLE);
    assign song_end = (state_q == ST_DONE);

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player: a note schedule computed from the note
// lengths predicts address, busy, song_end, note index and sample every cycle.
module tb_song_player;

    localparam int LAST = 3;
    localparam int TI   = 20;
    localparam int TF   = 10;
    localparam int TC   = 1;
    localparam int AMP  = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [9:0]  rom_addr;
    logic [19:0] rom_q;
    logic [31:0] sample;
    logic        busy;
    logic        song_end;
    logic [9:0]  note_idx;

    always #5 clk = ~clk;

    song_player #(
        .LAST_ADDR     (LAST),
        .TEMPO_INIT    (TI),
        .TEMPO_FAST    (TF),
        .TEMPO_CHG_ADDR(TC),
        .AMPL          (AMP)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .rom_addr(rom_addr),
        .rom_q   (rom_q),
        .sample  (sample),
        .busy    (busy),
        .song_end(song_end),
        .note_idx(note_idx)
    );

    // Song ROM with a two-cycle read latency.
    logic [19:0] rom_mem [4];
    logic [19:0] rom_r1;
    always @(posedge clk) begin
        rom_r1 <= rom_mem[rom_addr[1:0]];
        rom_q  <= rom_r1;
    end

    int checks = 0;
    int errors = 0;
    int note_start [16];
    int n_notes;
    int end_cycle;
    int obs_change [64];
    int n_change;
    int obs_end;

    // HOLD length of the k-th played note: fast once past the tempo-change note.
    function automatic int note_limit(input int k);
        return ((k % (LAST + 1)) > TC) ? TF : TI;
    endfunction

    // Each note = 2 fetch + 1 load + (limit+1) hold cycles; cycle 0 follows the start edge.
    task automatic plan(input bit lp);
        int t;
        t = 0;
        n_notes = lp ? 16 : LAST + 1;
        for (int i = 0; i < n_notes; i++) begin
            note_start[i] = t;
            t += note_limit(i) + 4;
        end
        end_cycle = lp ? -1 : t;
    endtask

    function automatic int note_at(input int m);
        int r;
        r = -1;
        for (int i = 0; i < n_notes; i++) if (note_start[i] <= m) r = i;
        return r;
    endfunction

    function automatic int sounding_at(input int m);
        int r;
        r = -1;
        for (int i = 0; i < n_notes; i++) if (note_start[i] + 3 <= m) r = i;
        return r;
    endfunction

    function automatic logic [31:0] tone_val(input int m);
        int k;
        int j;
        int hp;
        k = sounding_at(m);
        if (k < 0) return 32'd0;
        hp = int'(rom_mem[k % (LAST + 1)][18:0]);
        if (hp == 0) return 32'd0;
        j = m - (note_start[k] + 3);
        return (((j / (hp + 1)) % 2) == 1) ? 32'(-AMP) : 32'(AMP);
    endfunction

    task automatic run_song(input bit lp, input int ncycles, input int abort_at,
                            input int abort_kind, input bit rand_start);
        logic [31:0] exp_s;
        logic        live;
        logic [9:0]  prev_addr;
        int          k;
        plan(lp);
        n_change  = 0;
        obs_end   = -1;
        prev_addr = '0;
        @(negedge clk);
        loop_en = lp;
        stop    = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        for (int m = 0; m < ncycles; m++) begin
            @(negedge clk);
            live = (end_cycle < 0) || (m < end_cycle);
            if (live) begin
                k = note_at(m);
                checks++;
                if (rom_addr !== 10'(k % (LAST + 1))) begin
                    errors++;
                    $display("FAIL rom_addr cycle %0d got %0d want %0d", m, rom_addr, k % (LAST + 1));
                end
                k = sounding_at(m);
                if (k >= 0) begin
                    checks++;
                    if (note_idx !== 10'(k % (LAST + 1))) begin
                        errors++;
                        $display("FAIL note_idx cycle %0d got %0d want %0d", m, note_idx, k % (LAST + 1));
                    end
                end
            end
            checks++;
            if (busy !== ((end_cycle < 0) || (m <= end_cycle))) begin
                errors++;
                $display("FAIL busy cycle %0d got %b want %b", m, busy, (end_cycle < 0) || (m <= end_cycle));
            end
            checks++;
            if (song_end !== (m == end_cycle)) begin
                errors++;
                $display("FAIL song_end cycle %0d got %b want %b", m, song_end, m == end_cycle);
            end
            exp_s = (!live || m == 0) ? 32'd0 : tone_val(m - 1);
            checks++;
            if (sample !== exp_s) begin
                errors++;
                $display("FAIL sample cycle %0d got %0d want %0d", m, $signed(sample), $signed(exp_s));
            end
            if (m > 0 && rom_addr !== prev_addr && n_change < 64) begin
                obs_change[n_change] = m;
                n_change++;
            end
            prev_addr = rom_addr;
            if (song_end === 1'b1 && obs_end < 0) obs_end = m;
            if (m == abort_at) begin
                if (abort_kind == 1) stop = 1'b1;
                else reset = 1'b1;
                start = 1'b1;
                return;
            end
            start = (rand_start && live) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic random_rom();
        for (int i = 0; i < 4; i++) begin
            rom_mem[i] = {1'($urandom_range(0, 1)), 19'($urandom_range(0, 9))};
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) rom_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rom_addr, note_idx, sample, busy, song_end} !== 54'd0) begin
            errors++;
            $display("FAIL reset_state got addr=%0d idx=%0d sample=%0d busy=%b end=%b want all 0",
                     rom_addr, note_idx, sample, busy, song_end);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy got %b want 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_song();
        int exp_hold [4] = '{21, 21, 11, 11};
        int got_hold [4];
        rom_mem[0] = 20'd4;
        rom_mem[1] = 20'd0;
        rom_mem[2] = 20'd2;
        rom_mem[3] = 20'd5;
        plan(1'b0);
        run_song(1'b0, end_cycle + 5, -1, 0, 1'b1);
        checks++;
        if (n_change < 3 || obs_end < 0) begin
            errors++;
            $display("FAIL hold_lengths got %0d address changes end=%0d want 3 changes and an end", n_change, obs_end);
        end else begin
            got_hold[0] = obs_change[0] - 3;
            got_hold[1] = obs_change[1] - obs_change[0] - 3;
            got_hold[2] = obs_change[2] - obs_change[1] - 3;
            got_hold[3] = obs_end - obs_change[2] - 3;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_hold[i] != exp_hold[i]) begin
                    errors++;
                    $display("FAIL hold_len note %0d got %0d want %0d", i, got_hold[i], exp_hold[i]);
                end
            end
        end
        $display("test_song done");
    endtask

    task automatic test_random_songs();
        for (int it = 0; it < 3; it++) begin
            random_rom();
            plan(1'b0);
            run_song(1'b0, end_cycle + 4, -1, 0, 1'b1);
            $display("test_random_songs run %0d rom=%h %h %h %h", it, rom_mem[0], rom_mem[1], rom_mem[2], rom_mem[3]);
        end
    endtask

    task automatic test_loop();
        random_rom();
        run_song(1'b1, 180, -1, 0, 1'b1);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sample !== 32'd0 || song_end !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop got busy=%b sample=%0d end=%b want 0 0 0", busy, sample, song_end);
        end
        stop    = 1'b0;
        loop_en = 1'b0;
        $display("test_loop done");
    endtask

    task automatic test_stop();
        int at;
        rom_mem[0] = 20'd3;
        rom_mem[1] = 20'd6;
        rom_mem[2] = 20'd2;
        rom_mem[3] = 20'd5;
        plan(1'b0);
        at = note_start[2] + 3 + $urandom_range(0, TF);
        run_song(1'b0, end_cycle + 4, at, 1, 1'b0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sample !== 32'd0 || song_end !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold got busy=%b sample=%0d end=%b want 0 0 0", busy, sample, song_end);
        end
        stop  = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (song_end !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stop_quiet got busy=%b end=%b want 0 0", busy, song_end);
            end
        end
        plan(1'b0);
        run_song(1'b0, end_cycle + 3, -1, 0, 1'b0);
        $display("test_stop done at cycle %0d", at);
    endtask

    task automatic test_reset_fetch();
        int at;
        rom_mem[0] = 20'd2;
        rom_mem[1] = 20'd3;
        rom_mem[2] = 20'd1;
        rom_mem[3] = 20'd4;
        plan(1'b0);
        at = note_start[2] + $urandom_range(0, 1);
        run_song(1'b0, end_cycle + 4, at, 2, 1'b1);
        @(negedge clk);
        checks++;
        if ({rom_addr, note_idx, sample, busy, song_end} !== 54'd0) begin
            errors++;
            $display("FAIL reset_fetch got addr=%0d idx=%0d sample=%0d busy=%b end=%b want all 0",
                     rom_addr, note_idx, sample, busy, song_end);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch_idle busy got %b want 0", busy);
        end
        $display("test_reset_fetch done at cycle %0d", at);
    endtask

    initial begin
        test_reset();
        test_song();
        test_random_songs();
        test_loop();
        test_stop();
        test_reset_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
